// File: rtl/mdu_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mdu_control                                                   |
// | Purpose  : EX-stage multiply/divide unit. Decodes MULT/MULTU/DIV/DIVU    |
// |            and the HI/LO move functs, runs an iterative radix-2          |
// |            multiplier or a restoring divider, owns HI/LO and requests    |
// |            a pipeline stall while a long operation is in flight.         |
// | Option   : MDU_FAST_MUL_EN - single-cycle combinational multiplier       |
// |            (IDLE->FIX directly for MULT/MULTU). Divide is unaffected.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mdu_control #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [2:0]       i_aluop,
   input  logic [5:0]       i_funct,
   input  logic [WIDTH-1:0] i_rs,
   input  logic [WIDTH-1:0] i_rt,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_stall,
   output logic             o_done,
   output logic             o_div_by_zero,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam logic [2:0] C_ALUOP_R = 3'b010;
   localparam logic [5:0] C_MFHI    = 6'h10;
   localparam logic [5:0] C_MTHI    = 6'h11;
   localparam logic [5:0] C_MFLO    = 6'h12;
   localparam logic [5:0] C_MTLO    = 6'h13;
   localparam logic [5:0] C_MULT    = 6'h18;
   localparam logic [5:0] C_MULTU   = 6'h19;
   localparam logic [5:0] C_DIV     = 6'h1a;
   localparam logic [5:0] C_DIVU    = 6'h1b;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;          // multiplicand magnitude
   logic [WIDTH-1:0]     b_q, b_d;          // divisor magnitude
   logic [2*WIDTH-1:0]   acc_q, acc_d;      // {hi part, lo part} working register
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_q, neg_d;      // product / quotient needs negation
   logic                 rem_neg_q, rem_neg_d;
   logic                 dbz_q, dbz_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;
   logic                 dbz_out_q, dbz_out_d;

   logic                 rtype, is_long, is_mdu, accept, signed_op;
   logic [WIDTH-1:0]     rs_abs, rt_abs;
   logic [WIDTH:0]       mul_sum, div_part, div_diff;
   logic                 div_fit;
   logic [2*WIDTH-1:0]   prod, prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   // Instruction decode and operand magnitudes for signed ops
   always_comb begin
      rtype     = i_valid && (i_aluop == C_ALUOP_R);
      is_long   = (i_funct == C_MULT) || (i_funct == C_MULTU) ||
                  (i_funct == C_DIV)  || (i_funct == C_DIVU);
      is_mdu    = is_long || (i_funct == C_MFHI) || (i_funct == C_MTHI) ||
                  (i_funct == C_MFLO) || (i_funct == C_MTLO);
      accept    = rtype && is_long && (state_q == IDLE);
      signed_op = ~i_funct[0];
      rs_abs    = (signed_op && i_rs[WIDTH-1]) ? -i_rs : i_rs;
      rt_abs    = (signed_op && i_rt[WIDTH-1]) ? -i_rt : i_rt;
   end

   // One multiply/divide iteration plus the final sign correction
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      // Partial remainder shifted left with the next dividend bit
      div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_fit  = (div_part >= {1'b0, b_q});
      div_diff = div_part - {1'b0, b_q};
`ifdef MDU_FAST_MUL_EN
      prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`else
      prod     = acc_q;
`endif
      prod_fix = neg_q ? -prod : prod;
      // A zero divisor yields an all-ones quotient regardless of signs
      quo_fix  = dbz_q ? {WIDTH{1'b1}} :
                 (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      // With a zero divisor the remainder is |rs|, so this restores rs
      rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   // Next-state and datapath update for the IDLE/RUN/FIX sequencer
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = (state_q == FIX);
      dbz_out_d = (state_q == FIX) && is_div_q && dbz_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d       = rs_abs;
               b_d       = rt_abs;
               is_div_d  = i_funct[1];
               neg_d     = signed_op && (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
               rem_neg_d = signed_op && i_rs[WIDTH-1];
               dbz_d     = (i_rt == {WIDTH{1'b0}});
               cnt_d     = CNT_W'(WIDTH);
               acc_d     = i_funct[1] ? {{WIDTH{1'b0}}, rs_abs}
                                      : {{WIDTH{1'b0}}, rt_abs};
               state_d   = RUN;
`ifdef MDU_FAST_MUL_EN
               if (!i_funct[1]) begin
                  state_d = FIX;
               end
`endif
            end else if (rtype && (i_funct == C_MTHI)) begin
               hi_d = i_rs;
            end else if (rtype && (i_funct == C_MTLO)) begin
               lo_d = i_rs;
            end
         end
         RUN: begin
            if (is_div_q) begin
               acc_d = {(div_fit ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_fit};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_out_q <= dbz_out_d;
      end
   end

   assign o_ready       = (state_q == IDLE);
   assign o_busy        = (state_q != IDLE);
   assign o_stall       = rtype && is_mdu && (state_q != IDLE);
   assign o_done        = done_q;
   assign o_div_by_zero = dbz_out_q;
   assign o_hi          = hi_q;
   assign o_lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mdu_control                                                |
// | Purpose  : Scoreboard bench for mdu_control with a behavioural model     |
// |            (plain 64-bit arithmetic). Honours MDU_FAST_MUL_EN latency.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mdu_control;

   localparam logic [2:0] R = 3'b010;

   logic        clk, rst_n, valid;
   logic [2:0]  aluop;
   logic [5:0]  funct;
   logic [31:0] rs, rt;
   logic        ready, busy, stall, done, dbz;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          due;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          busy_until = -1;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   mdu_control #(.WIDTH(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_aluop(aluop),
      .i_funct(funct), .i_rs(rs), .i_rt(rt), .o_ready(ready), .o_busy(busy),
      .o_stall(stall), .o_done(done), .o_div_by_zero(dbz), .o_hi(hi), .o_lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit is_mdu(input logic [5:0] f);
      return f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};
   endfunction

   function automatic bit is_long(input logic [5:0] f);
      return f inside {6'h18, 6'h19, 6'h1a, 6'h1b};
   endfunction

   // Cycles from the negedge before acceptance to the negedge showing o_done
   function automatic int latency(input logic [5:0] f);
`ifdef MDU_FAST_MUL_EN
      if (f == 6'h18 || f == 6'h19) return 2;
`endif
      return 34;
   endfunction

   // Reference results straight from architectural arithmetic
   function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      sa, sb, sp, sq, sr;
      logic [63:0] ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      e.dbz = 1'b0;
      e.due = 0;
      e.hi  = '0;
      e.lo  = '0;
      case (f)
         6'h18: begin sp = sa * sb; up = sp; e.hi = up[63:32]; e.lo = up[31:0]; end
         6'h19: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
         default: begin
            if (b == 32'd0) begin
               e.hi = a; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
            end else if (f == 6'h1a) begin
               sq = sa / sb; sr = sa % sb;
               up = sq; e.lo = up[31:0];
               up = sr; e.hi = up[31:0];
            end else begin
               up = ua / ub; e.lo = up[31:0];
               up = ua % ub; e.hi = up[31:0];
            end
         end
      endcase
      return e;
   endfunction

   // Present one instruction, holding it while stalled, then update the model
   task automatic present(input logic [2:0] al, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
      logic est;
      int   guard, ic;
      bit   held;
      exp_t e;
      @(negedge clk);
      valid = 1'b1; aluop = al; funct = f; rs = a; rt = b;
      guard = 0;
      held  = 1'b1;
      while (held) begin
         #1;
         est = (al == R) && is_mdu(f) && (cyc <= busy_until);
         chk("stall", {63'b0, stall}, {63'b0, est});
         if (!est) begin
            held = 1'b0;
         end else begin
            guard++;
            if (guard > 100) begin
               checks++; errors++;
               $display("FAIL stall_timeout funct=%h still stalled after %0d cycles", f, guard);
               held = 1'b0;
            end else begin
               @(negedge clk);
            end
         end
      end
      ic = cyc;
      @(posedge clk);
      #1;
      if (al == R) begin
         if (is_long(f)) begin
            e = model(f, a, b);
            e.due = ic + latency(f);
            busy_until = e.due - 1;
            sb_q.push_back(e);
            model_hi = e.hi;
            model_lo = e.lo;
         end else if (f == 6'h11) begin
            model_hi = a;
            chk("mthi", {32'b0, hi}, {32'b0, a});
         end else if (f == 6'h13) begin
            model_lo = a;
            chk("mtlo", {32'b0, lo}, {32'b0, a});
         end else if (f == 6'h10) begin
            chk("mfhi", {32'b0, hi}, {32'b0, model_hi});
         end else if (f == 6'h12) begin
            chk("mflo", {32'b0, lo}, {32'b0, model_lo});
         end
      end
      valid = 1'b0;
   endtask

   // Monitor: state flags every cycle, results when the scoreboard says due
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         chk("busy", {63'b0, busy}, {63'b0, (cyc <= busy_until)});
         chk("ready", {63'b0, ready}, {63'b0, !(cyc <= busy_until)});
         if (sb_q.size() > 0 && cyc >= sb_q[0].due) begin
            e = sb_q.pop_front();
            chk("done", {63'b0, done}, 64'd1);
            chk("hi", {32'b0, hi}, {32'b0, e.hi});
            chk("lo", {32'b0, lo}, {32'b0, e.lo});
            chk("div_by_zero", {63'b0, dbz}, {63'b0, e.dbz});
         end else begin
            chk("no_done", {63'b0, done}, 64'd0);
            chk("no_dbz", {63'b0, dbz}, 64'd0);
         end
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      logic [5:0] f;
      logic [5:0] others [4];
      others[0] = 6'h20; others[1] = 6'h21; others[2] = 6'h2a; others[3] = 6'h14;
      rst_n = 1'b0; valid = 1'b0; aluop = '0; funct = '0; rs = '0; rt = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", {63'b0, ready}, 64'd1);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_done", {63'b0, done}, 64'd0);
      chk("rst_dbz", {63'b0, dbz}, 64'd0);
      chk("rst_hi", {32'b0, hi}, 64'd0);
      chk("rst_lo", {32'b0, lo}, 64'd0);
      rst_n = 1'b1;

      // Directed cases
      present(R, 6'h18, 32'hFFFFFFFD, 32'd7);
      present(R, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
      present(R, 6'h1a, 32'hFFFFFFF9, 32'd2);
      present(R, 6'h1b, 32'd7, 32'd2);
      present(R, 6'h1a, 32'h80000000, 32'hFFFFFFFF);
      present(R, 6'h1a, 32'h12345678, 32'd0);
      present(R, 6'h1b, 32'hDEADBEEF, 32'd0);
      present(R, 6'h1a, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      present(R, 6'h12, 32'd0, 32'd0);       // MFLO stalls until the done cycle
      present(R, 6'h13, 32'h000000A5, 32'd0);
      present(R, 6'h11, 32'h0000005A, 32'd0);
      present(R, 6'h10, 32'd0, 32'd0);
      present(3'b000, 6'h18, 32'd5, 32'd5);  // not R-type: ignored

      // Randomized mix
      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: f = 6'h18 + 6'($urandom_range(0, 3));
            4:          f = 6'h11 + 6'(2 * $urandom_range(0, 1));
            5:          f = 6'h10 + 6'(2 * $urandom_range(0, 1));
            6:          f = others[$urandom_range(0, 3)];
            default:    f = 6'h18 + 6'($urandom_range(0, 3));
         endcase
         if ($urandom_range(0, 9) == 0)
            present(3'($urandom_range(3, 7)), f, pick(), pick());
         else
            present(R, f, pick(), pick());
      end

      // Reset in the middle of a divide
      present(R, 6'h11, 32'h5A5A5A5A, 32'd0);
      present(R, 6'h1a, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {63'b0, busy}, 64'd0);
      chk("abort_ready", {63'b0, ready}, 64'd1);
      chk("abort_hi", {32'b0, hi}, 64'd0);
      chk("abort_lo", {32'b0, lo}, 64'd0);
      sb_q.delete();
      busy_until = -1;
      model_hi = '0;
      model_lo = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (45) @(negedge clk);
      present(R, 6'h19, 32'd12345, 32'd678);

      for (int k = 0; k < 100 && sb_q.size() > 0; k++) @(negedge clk);
      if (sb_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL drain %0d results never appeared", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mdu_control.md
Name: mdu_control

Overview:
- Parametrised successor to the ALU decode stage for the EX stage of the pipelined MIPS core.
- Decodes R-type multiply, divide and HI/LO move functs.
- Runs an iterative radix-2 multiplier and a restoring divider, and owns the HI/LO registers.
- Drives a stall request to the hazard unit while a long operation is in flight.

Parameters:
- WIDTH, 32: operand width. HI and LO are WIDTH bits each; the product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  EX-stage instruction valid.
- i_aluop  in  3  ALU op class. Only 3'b010 (R type) is acted on.
- i_funct  in  6  instruction funct field.
- i_rs  in  WIDTH  operand A (dividend / multiplicand / MTxx source).
- i_rt  in  WIDTH  operand B (divisor / multiplier).
- o_ready  out  1  unit idle, can accept MULT/DIV.
- o_busy  out  1  multiply or divide in progress.
- o_stall  out  1  EX must hold the current instruction (combinational).
- o_done  out  1  one-cycle pulse: new HI/LO are visible this cycle.
- o_div_by_zero  out  1  pulses with o_done for a DIV/DIVU whose divisor was 0.
- o_hi  out  WIDTH  HI register.
- o_lo  out  WIDTH  LO register.

Behaviour:
- Decoded functs (only when i_valid and i_aluop==3'b010):
  - MULT 0x18, MULTU 0x19, DIV 0x1a, DIVU 0x1b.
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - Any other funct or aluop is ignored (no state change, o_stall=0).
- Reset: state IDLE. o_hi=o_lo=0, o_busy=0, o_done=0, o_div_by_zero=0, o_ready=1. An assertion mid-operation aborts immediately and no o_done follows.
- FSM has three states: IDLE, RUN, FIX.
- IDLE:
  - An accepted MULT/MULTU/DIV/DIVU latches |rs|, |rt| (signed ops; raw values for unsigned ops), the sign flags, op kind, and counter=WIDTH.
  - Next state is RUN.
  - MTHI/MTLO write o_hi/o_lo at this edge, with no stall.
- RUN: one iteration per cycle, counter decrements. On counter reaching 1, next state is FIX.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing WIDTH-bit quotient and remainder.
- FIX (1 cycle):
  - Signed MULT: negate the 2*WIDTH product if the operand signs differ. HI=product[2W-1:W], LO=product[W-1:0].
  - Signed DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign. LO=quotient, HI=remainder (quotient truncates toward zero).
  - Write HI/LO, then return to IDLE. o_done (and o_div_by_zero where applicable) are registered, high in the first IDLE cycle.
- Latency: acceptance edge E0; HI/LO updated at edge E0+WIDTH+1; o_done high in the cycle that follows.
- o_busy = (state != IDLE). o_ready = (state == IDLE).
- o_stall = i_valid & R-type & busy & funct in {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO}.
  - A stalled instruction is not accepted and is re-presented by the pipeline.
- Divide by zero: no trap. HI = dividend as issued (rs), LO = all ones, o_div_by_zero=1 with o_done. Full latency still applies.
- Signed overflow (-2^(W-1) / -1): LO = -2^(W-1), HI = 0 (natural wrap, no flag).
- Simultaneous events:
  - MTxx presented in the FIX cycle stalls, because busy=1 in FIX.
  - Issue in the o_done cycle is accepted normally.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle combinational WIDTH x WIDTH multiplier, going IDLE->FIX directly. HI/LO are updated at edge E0+1 and o_done is high in the next cycle. Divide is unchanged.
- Undefined: multiply is iterative, with the same latency as divide (WIDTH+2 cycles to o_done).

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> o_done high 34 cycles after issue, HI=0xFFFFFFFF, LO=0xFFFFFFEB, o_stall=0 for the issuing instruction.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Repeat with MDU_FAST_MUL_EN -> o_done 2 cycles after issue.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV rs=0x12345678, rt=0 -> HI=0x12345678, LO=0xFFFFFFFF, o_div_by_zero=1 for exactly one cycle with o_done.
- MFLO presented 5 cycles after a DIV issue -> o_stall=1 until o_done cycle, then 0. MTLO 0x000000A5 while idle -> o_lo=0xA5 the next cycle, o_stall=0.
- i_rst_n low at cycle 10 of a DIV -> o_busy=0, o_hi=o_lo=0 immediately (before next clock); no o_done pulse after release.
